ram_dp_be: RTL and testbench
============================

Name: ram_dp_be

Overview:
Parametrised simple-dual-port synchronous RAM: one write port, one read port, one clock. Adds per-byte write enables, a selectable read-during-write policy and an optional output pipeline register. A read-valid strobe accompanies every read. A reset-triggered clear engine zeroes the whole array and reports busy while it runs. Used for register files, data memory and scratch buffers in the datapath.

Parameters:
dataWidth, 16, bits per word; must be a multiple of byteWidth.
addrWidth, 8, address bits; depth = 2**addrWidth.
byteWidth, 8, bits per write-enable lane; lanes = dataWidth/byteWidth.
rdwMode, 0, same-address read during write: 0 = read-first (old data), 1 = write-first (new merged data).
outReg, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
clearOnReset, 1, 1 = zero the array after reset; 0 = no clear, initial contents come from filename.
filename, "data.txt", $readmemb init file; used only when clearOnReset = 0.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
write  input  1  write request.
writeAddress  input  addrWidth  write address.
byteEnable  input  lanes  per-lane write enable; lane i covers in[i*byteWidth +: byteWidth].
in  input  dataWidth  write data.
read  input  1  read request.
readAddress  input  addrWidth  read address.
out  output  dataWidth  read data; holds its value between reads.
outValid  output  1  one-cycle pulse, aligned with new data on out.
busy  output  1  high while clear is running; port requests ignored.

Behaviour:
- Reset (reset = 1 at posedge): out = 0, outValid = 0, output pipeline stage flushed (its data = 0, valid = 0). Next state = CLEAR when clearOnReset = 1, else IDLE. busy = 1 in the cycle after reset when clearOnReset = 1, else 0.
- FSM states: IDLE, CLEAR. CLEAR: clear counter starts at 0 and writes 0 to mem[counter] each cycle, then increments. After the write to address depth-1: -> IDLE, busy = 0. Clear therefore takes exactly depth cycles after reset deasserts.
- Reset asserted mid-clear: counter restarts at 0 and the clear runs in full again.
- During CLEAR, write and read are ignored. No memory write and no outValid pulse come from a request in this state.
- Write (IDLE, write = 1): for each lane i with byteEnable[i] = 1, mem[writeAddress] lane i = in lane i; other lanes keep their value. byteEnable = 0 means no change.
- Read (IDLE, read = 1) at edge N. outReg = 0: out and outValid = 1 update at edge N. outReg = 1: they update at edge N+1. outValid is 0 in every cycle that has no read result. out is not updated when read = 0.
- Back-to-back reads are fully pipelined: one result per cycle.
- Same-address read and write at one edge: rdwMode 0 returns the pre-write word. rdwMode 1 returns the merged word: enabled lanes from in, other lanes from the old word.
- Address wrap: none; every addrWidth value is a valid location.
- Arithmetic: clear counter is addrWidth+1 bits wide so that terminal detection does not alias.

Decomposition:
- Shared package ram_pkg holds the state enum (IDLE, CLEAR) and the rdwMode constants (RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1).
- Sub-module ram_clear_fsm holds the FSM, clear counter and busy logic. Its outputs are clrWrite, clrAddr and busy. The top level muxes these onto the write port and gates user requests with busy.

Test Plan:
- Reset clear (addrWidth = 4, clearOnReset = 1): pulse reset for 1 cycle -> busy high for exactly 16 cycles. Reads of 0..15 then return 0x0000 with outValid at latency 1.
- Byte enables: write 0xABCD to addr 3 with byteEnable = 11, then write 0x1234 with byteEnable = 01 -> a read of addr 3 returns 0xAB34.
- Read-during-write: addr 5 holds 0x1111; write 0x2222 (byteEnable = 11) and read addr 5 at the same edge -> out = 0x1111 with rdwMode = 0, 0x2222 with rdwMode = 1.
- Latency and pipelining, outReg = 1: reads of addr 1, 2, 3 on consecutive cycles (holding 0x0001, 0x0002, 0x0003) -> outValid high for 3 cycles starting 2 edges after the first read, data in order. out holds 0x0003 afterwards.
- Reset mid-clear: assert reset at clear cycle 7 -> busy stays high and the counter restarts. Total busy duration is 16 cycles after the second reset deasserts.
- Requests during busy: write 0xFFFF to addr 2 and read addr 2 while busy -> no outValid pulse; after clear, addr 2 reads 0x0000.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enable dual-port RAM.
// Clear FSM states and read-during-write policy codes.
package ram_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: walks every address once after reset, writing zero.
// Drives busy so the top can gate user requests while clearing.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int addrWidth    = 8,
  parameter int clearOnReset = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 clrWrite,
  output logic [addrWidth-1:0] clrAddr,
  output logic                 busy
);

  localparam int Depth = 1 << addrWidth;
  // One spare bit keeps the terminal compare from aliasing.
  localparam logic [addrWidth:0] Last = (addrWidth+1)'(Depth - 1);

  state_t               state_q, state_d;
  logic [addrWidth:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (clearOnReset != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clrWrite = 1'b0;
    clrAddr  = cnt_q[addrWidth-1:0];
    busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
      end
      CLEAR: begin
        busy     = 1'b1;
        clrWrite = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == Last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte enables, selectable read-during-write
// policy, optional output register and a post-reset clear engine.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int    dataWidth    = 16,
  parameter int    addrWidth    = 8,
  parameter int    byteWidth    = 8,
  parameter int    rdwMode      = 0,
  parameter int    outReg       = 0,
  parameter int    clearOnReset = 1,
  parameter string filename     = "data.txt"
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           write,
  input  logic [addrWidth-1:0]           writeAddress,
  input  logic [dataWidth/byteWidth-1:0] byteEnable,
  input  logic [dataWidth-1:0]           in,
  input  logic                           read,
  input  logic [addrWidth-1:0]           readAddress,
  output logic [dataWidth-1:0]           out,
  output logic                           outValid,
  output logic                           busy
);

  localparam int Lanes = dataWidth / byteWidth;
  localparam int Depth = 1 << addrWidth;

  logic [dataWidth-1:0] mem [Depth];

  logic                 clrWrite;
  logic [addrWidth-1:0] clrAddr;
  logic                 userWr, userRd;
  logic [dataWidth-1:0] rdWord, fwdWord;
  logic [dataWidth-1:0] rd_q;
  logic                 rv_q;

  ram_clear_fsm #(
    .addrWidth    (addrWidth),
    .clearOnReset (clearOnReset)
  ) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clrWrite (clrWrite),
    .clrAddr  (clrAddr),
    .busy     (busy)
  );

  assign userWr = write & ~busy & ~reset;
  assign userRd = read & ~busy & ~reset;

  always_ff @(posedge clk) begin
    if (clrWrite) begin
      mem[clrAddr] <= '0;
    end else if (userWr) begin
      for (int i = 0; i < Lanes; i++) begin
        if (byteEnable[i]) begin
          mem[writeAddress][i*byteWidth +: byteWidth] <=
            in[i*byteWidth +: byteWidth];
        end
      end
    end
  end

  // Write-first bypass merges enabled lanes of the incoming word.
  always_comb begin
    rdWord  = mem[readAddress];
    fwdWord = rdWord;
    if (rdwMode == RDW_WRITE_FIRST && userWr &&
        writeAddress == readAddress) begin
      for (int i = 0; i < Lanes; i++) begin
        if (byteEnable[i]) begin
          fwdWord[i*byteWidth +: byteWidth] =
            in[i*byteWidth +: byteWidth];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= userRd;
      if (userRd) begin
        rd_q <= fwdWord;
      end
    end
  end

  if (outReg != 0) begin : g_oreg
    logic [dataWidth-1:0] or_q;
    logic                 ov_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        or_q <= '0;
        ov_q <= 1'b0;
      end else begin
        ov_q <= rv_q;
        if (rv_q) begin
          or_q <= rd_q;
        end
      end
    end

    assign out      = or_q;
    assign outValid = ov_q;
  end else begin : g_noreg
    assign out      = rd_q;
    assign outValid = rv_q;
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench: three RAM variants share one stimulus stream.
// u0 read-first/1-cycle, u1 write-first/1-cycle, u2 read-first/2-cycle.
module tb_ram_dp_be;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [3:0]  writeAddress;
  logic [1:0]  byteEnable;
  logic [15:0] in;
  logic        read;
  logic [3:0]  readAddress;

  logic [15:0] out0, out1, out2;
  logic        ov0, ov1, ov2;
  logic        busy0, busy1, busy2;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  ram_dp_be #(.addrWidth(4), .rdwMode(0), .outReg(0)) u0 (
    .clk(clk), .reset(reset), .write(write),
    .writeAddress(writeAddress), .byteEnable(byteEnable),
    .in(in), .read(read), .readAddress(readAddress),
    .out(out0), .outValid(ov0), .busy(busy0)
  );

  ram_dp_be #(.addrWidth(4), .rdwMode(1), .outReg(0)) u1 (
    .clk(clk), .reset(reset), .write(write),
    .writeAddress(writeAddress), .byteEnable(byteEnable),
    .in(in), .read(read), .readAddress(readAddress),
    .out(out1), .outValid(ov1), .busy(busy1)
  );

  ram_dp_be #(.addrWidth(4), .rdwMode(0), .outReg(1)) u2 (
    .clk(clk), .reset(reset), .write(write),
    .writeAddress(writeAddress), .byteEnable(byteEnable),
    .in(in), .read(read), .readAddress(readAddress),
    .out(out2), .outValid(ov2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d,
                    input logic [1:0] be);
    write = 1'b1; writeAddress = a; in = d; byteEnable = be;
    read = 1'b0;
    tick();
    write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; writeAddress = '0; byteEnable = '0;
    in = '0; read = 1'b0; readAddress = '0;

    tick();
    chk("rst_out0", out0, 16'h0000);
    chk("rst_ov0", {15'd0, ov0}, 16'd0);
    chk("rst_out2", out2, 16'h0000);
    chk("rst_ov2", {15'd0, ov2}, 16'd0);
    chk("rst_busy", {15'd0, busy0}, 16'd1);
    reset = 1'b0;

    // Requests during busy must be ignored.
    write = 1'b1; writeAddress = 4'd2; in = 16'hFFFF; byteEnable = 2'b11;
    read = 1'b1; readAddress = 4'd2;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("busy_mid", {15'd0, busy0}, 16'd1);
      chk("ov_busy", {15'd0, ov0}, 16'd0);
    end

    reset = 1'b1;
    tick();
    chk("busy_rerst", {15'd0, busy0}, 16'd1);
    reset = 1'b0;

    n = 0;
    while (busy0 && n < 40) begin
      tick();
      n++;
      if (busy0) chk("ov_busy2", {15'd0, ov0}, 16'd0);
    end
    chk("clear_len", 16'(n), 16'd16);
    chk("busy_u2", {15'd0, busy2}, 16'd0);
    write = 1'b0; read = 1'b0;

    for (int a = 0; a < 16; a++) begin
      read = 1'b1; readAddress = 4'(a);
      tick();
      chk("clr_data", out0, 16'h0000);
      chk("clr_valid", {15'd0, ov0}, 16'd1);
    end
    read = 1'b0;
    tick();
    chk("idle_ov", {15'd0, ov0}, 16'd0);
    chk("hold_out", out0, 16'h0000);

    wr(4'd3, 16'hABCD, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    read = 1'b1; readAddress = 4'd3;
    tick();
    chk("be_merge", out0, 16'hAB34);
    read = 1'b0;

    wr(4'd5, 16'h1111, 2'b11);
    write = 1'b1; writeAddress = 4'd5; in = 16'h2222; byteEnable = 2'b11;
    read = 1'b1; readAddress = 4'd5;
    tick();
    chk("rdw_rf", out0, 16'h1111);
    chk("rdw_wf", out1, 16'h2222);
    write = 1'b1; writeAddress = 4'd5; in = 16'h3344; byteEnable = 2'b01;
    read = 1'b1; readAddress = 4'd5;
    tick();
    chk("rdw_rf_be", out0, 16'h2222);
    chk("rdw_wf_be", out1, 16'h2244);
    write = 1'b0;
    read = 1'b1; readAddress = 4'd5;
    tick();
    chk("rdw_after", out0, 16'h2244);
    read = 1'b0;

    wr(4'd1, 16'h0001, 2'b11);
    wr(4'd2, 16'h0002, 2'b11);
    wr(4'd3, 16'h0003, 2'b11);
    read = 1'b1; readAddress = 4'd1;
    tick();
    chk("pipe_v0", {15'd0, ov2}, 16'd0);
    readAddress = 4'd2;
    tick();
    chk("pipe_v1", {15'd0, ov2}, 16'd1);
    chk("pipe_d1", out2, 16'h0001);
    readAddress = 4'd3;
    tick();
    chk("pipe_v2", {15'd0, ov2}, 16'd1);
    chk("pipe_d2", out2, 16'h0002);
    read = 1'b0;
    tick();
    chk("pipe_v3", {15'd0, ov2}, 16'd1);
    chk("pipe_d3", out2, 16'h0003);
    tick();
    chk("pipe_v4", {15'd0, ov2}, 16'd0);
    chk("pipe_hold", out2, 16'h0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
